// File: rtl/noc_rsp_arb_pkg.sv
// Shared types and constants for the NoC response-lane arbiter.
// Defines the arbiter state encoding and the idle/NOP lane value.
package noc_rsp_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_XFER,
    ARB_GAP
  } arb_state_t;

  localparam logic       NOC_IDLE_CTL  = 1'b1;
  localparam logic [7:0] NOC_IDLE_DATA = 8'h00;
  localparam int         CNT_W         = 8;

endpackage

// File: rtl/noc_rsp_arb_pick.sv
// Combinational round-robin picker: returns the first requester at or after i_ptr,
// wrapping cyclically, plus a flag saying whether anyone is requesting.
module rr_arb_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         i_req,
  input  logic [$clog2(N_REQ)-1:0] i_ptr,
  output logic [$clog2(N_REQ)-1:0] o_gnt_id,
  output logic                     o_any
);

  localparam int IW = $clog2(N_REQ);

  int w_idx;

  // Scan offsets from far to near so the nearest valid requester overwrites last.
  always_comb begin
    o_gnt_id = '0;
    o_any    = 1'b0;
    w_idx    = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = (int'(i_ptr) + k) % N_REQ;
      if (i_req[IW'(w_idx)]) begin
        o_gnt_id = IW'(w_idx);
        o_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_rsp_arb.sv
// Packet-atomic round-robin arbiter sharing the device->NoC byte lane among N_REQ
// response sources; owns framing (ctl=1 on header byte) and the inter-packet gap.
module noc_rsp_arb
  import noc_rsp_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int MAX_PKT = 136,
  parameter int GAP     = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_REQ-1:0]         i_req_valid,
  input  logic [N_REQ*8-1:0]       i_req_data,
  input  logic [N_REQ-1:0]         i_req_last,
  output logic [N_REQ-1:0]         o_req_ready,
  output logic                     o_noc_from_dev_ctl,
  output logic [7:0]               o_noc_from_dev_data,
  output logic [$clog2(N_REQ)-1:0] o_grant_id,
  output logic                     o_busy,
  output logic                     o_err_underrun,
  output logic                     o_err_overlen
);

  localparam int IW = $clog2(N_REQ);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [IW-1:0]    r_rr_ptr;
  logic [IW-1:0]    r_grant_id;
  logic [CNT_W-1:0] r_byte_cnt;
  logic             r_ctl;
  logic [7:0]       r_data;
  logic             r_busy;
  logic             r_err_underrun;
  logic             r_err_overlen;

  logic [IW-1:0]    w_pick_id;
  logic             w_pick_any;
  logic [7:0]       w_req_bytes [N_REQ];
  logic             w_cur_valid;
  logic             w_cur_last;
  logic [7:0]       w_cur_data;
  logic             w_accept;
  logic             w_hit_max;
  logic             w_end;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign w_req_bytes[g] = i_req_data[8*g +: 8];
  end

  rr_arb_pick #(.N_REQ(N_REQ)) u_pick (
    .i_req    (i_req_valid),
    .i_ptr    (r_rr_ptr),
    .o_gnt_id (w_pick_id),
    .o_any    (w_pick_any)
  );

  assign w_cur_valid = i_req_valid[r_grant_id];
  assign w_cur_last  = i_req_last[r_grant_id];
  assign w_cur_data  = w_req_bytes[r_grant_id];
  assign w_accept    = (r_state == ARB_XFER) && w_cur_valid;
  assign w_hit_max   = (r_byte_cnt == CNT_W'(MAX_PKT - 1));
  assign w_end       = w_accept && (w_cur_last || w_hit_max);

  always_comb begin
    o_req_ready = '0;
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE: if (w_pick_any) w_state_nxt = ARB_XFER;
      ARB_XFER: begin
        o_req_ready[r_grant_id] = 1'b1;
        if (w_end) w_state_nxt = (GAP != 0) ? ARB_GAP : ARB_IDLE;
      end
      ARB_GAP:  w_state_nxt = ARB_IDLE;
      default:  w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= ARB_IDLE;
      r_rr_ptr       <= '0;
      r_grant_id     <= '0;
      r_byte_cnt     <= '0;
      r_ctl          <= NOC_IDLE_CTL;
      r_data         <= NOC_IDLE_DATA;
      r_busy         <= 1'b0;
      r_err_underrun <= 1'b0;
      r_err_overlen  <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_busy         <= (w_state_nxt != ARB_IDLE);
      r_ctl          <= NOC_IDLE_CTL;
      r_data         <= NOC_IDLE_DATA;
      r_err_underrun <= 1'b0;
      r_err_overlen  <= 1'b0;
      if (r_state == ARB_IDLE && w_pick_any) r_grant_id <= w_pick_id;
      if (w_accept) begin
        r_ctl  <= (r_byte_cnt == '0);
        r_data <= w_cur_data;
        if (w_end) begin
          r_byte_cnt    <= '0;
          r_rr_ptr      <= (r_grant_id == IW'(N_REQ - 1)) ? '0 : r_grant_id + IW'(1);
          r_err_overlen <= w_hit_max && !w_cur_last;
        end else if (r_byte_cnt < CNT_W'(MAX_PKT)) begin
          r_byte_cnt <= r_byte_cnt + CNT_W'(1);
        end
      end else if (r_state == ARB_XFER && r_byte_cnt != '0) begin
        // Mid-packet starvation: lane goes idle for this slot, grant is held.
        r_err_underrun <= 1'b1;
      end
    end
  end

  assign o_noc_from_dev_ctl  = r_ctl;
  assign o_noc_from_dev_data = r_data;
  assign o_grant_id          = r_grant_id;
  assign o_busy              = r_busy;
  assign o_err_underrun      = r_err_underrun;
  assign o_err_overlen       = r_err_overlen;

endmodule

// File: tb/tb_noc_rsp_arb.sv
// Directed bench for noc_rsp_arb: cycle tables for framing/underrun/overlength,
// plus queue-driven sources for arbitration order and reset-mid-packet cases.
module tb_noc_rsp_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  valid;
  logic [31:0] data;
  logic [3:0]  last;
  logic [3:0]  ready;
  logic        ctl;
  logic [7:0]  ldata;
  logic [1:0]  gid;
  logic        busy;
  logic        uu;
  logic        ov;

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;

  always #5 clk = ~clk;

  noc_rsp_arb #(.N_REQ(4), .MAX_PKT(8), .GAP(1)) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_req_valid         (valid),
    .i_req_data          (data),
    .i_req_last          (last),
    .o_req_ready         (ready),
    .o_noc_from_dev_ctl  (ctl),
    .o_noc_from_dev_data (ldata),
    .o_grant_id          (gid),
    .o_busy              (busy),
    .o_err_underrun      (uu),
    .o_err_overlen       (ov)
  );

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  last;
    logic [17:0] exp;
  } vec_t;

  vec_t tbl[$];

  // exp packs {ready, ctl, lane data, busy, grant_id, underrun, overlen}
  function automatic vec_t v(input int va, input int d, input int la, input int rdy,
                             input int c, input int ld, input int b, input int g,
                             input int u, input int o);
    vec_t r;
    r.valid = 4'(va);
    r.data  = 32'(d);
    r.last  = 4'(la);
    r.exp   = {4'(rdy), 1'(c), 8'(ld), 1'(b), 2'(g), 1'(u), 1'(o)};
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  logic [7:0] s_arr [4][8];
  int         s_pos [4];
  int         s_len [4];
  logic [7:0] cap_d[$];
  logic       cap_c[$];
  logic [1:0] cap_g[$];
  int         cap_t[$];

  task automatic load(input int src, input int n, input int base);
    for (int k = 0; k < n; k++) s_arr[src][k] = 8'(base + k);
    s_pos[src] = 0;
    s_len[src] = n;
  endtask

  task automatic cap_clear();
    cap_d.delete(); cap_c.delete(); cap_g.delete(); cap_t.delete();
  endtask

  // One cycle of queue-driven sources; captures every non-idle lane byte.
  task automatic cyc();
    for (int i = 0; i < 4; i++) begin
      valid[i]       = (s_pos[i] < s_len[i]);
      data[8*i +: 8] = valid[i] ? s_arr[i][s_pos[i]] : 8'h00;
      last[i]        = valid[i] && (s_pos[i] == s_len[i] - 1);
    end
    @(negedge clk);
    if (!(ctl == 1'b1 && ldata == 8'h00)) begin
      cap_d.push_back(ldata); cap_c.push_back(ctl);
      cap_g.push_back(gid);   cap_t.push_back(cyc_n);
    end
    for (int i = 0; i < 4; i++) if (valid[i] && ready[i]) s_pos[i]++;
    cyc_n++;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin s_pos[i] = 0; s_len[i] = 0; end
    cyc(); cyc();
    rst = 1'b0;
    cap_clear();
  endtask

  initial begin
    rst = 1'b1; valid = '0; data = '0; last = '0;
    for (int i = 0; i < 4; i++) begin s_pos[i] = 0; s_len[i] = 0; end
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {14'd0, ready, ctl, ldata, busy, gid, uu, ov},
        {14'd0, 4'b0000, 1'b1, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0});
    rst = 1'b0;

    // Basic packet from src0
    tbl.push_back(v(1, 'h05, 0, 0, 1, 'h00, 0, 0, 0, 0));
    tbl.push_back(v(1, 'h05, 0, 1, 1, 'h00, 1, 0, 0, 0));
    tbl.push_back(v(1, 'hAA, 0, 1, 1, 'h05, 1, 0, 0, 0));
    tbl.push_back(v(1, 'hBB, 0, 1, 0, 'hAA, 1, 0, 0, 0));
    tbl.push_back(v(1, 'h17, 0, 1, 0, 'hBB, 1, 0, 0, 0));
    tbl.push_back(v(1, 'h12, 1, 1, 0, 'h17, 1, 0, 0, 0));
    tbl.push_back(v(0, 'h00, 0, 0, 0, 'h12, 1, 0, 0, 0));
    tbl.push_back(v(0, 'h00, 0, 0, 1, 'h00, 0, 0, 0, 0));
    // Underrun: src0 stalls two cycles after its 2nd byte
    tbl.push_back(v(1, 'h11, 0, 0, 1, 'h00, 0, 0, 0, 0));
    tbl.push_back(v(1, 'h11, 0, 1, 1, 'h00, 1, 0, 0, 0));
    tbl.push_back(v(1, 'h22, 0, 1, 1, 'h11, 1, 0, 0, 0));
    tbl.push_back(v(0, 'h00, 0, 1, 0, 'h22, 1, 0, 0, 0));
    tbl.push_back(v(0, 'h00, 0, 1, 1, 'h00, 1, 0, 1, 0));
    tbl.push_back(v(1, 'h33, 1, 1, 1, 'h00, 1, 0, 1, 0));
    tbl.push_back(v(0, 'h00, 0, 0, 0, 'h33, 1, 0, 0, 0));
    tbl.push_back(v(0, 'h00, 0, 0, 1, 'h00, 0, 0, 0, 0));
    // Over-length: src1 streams without last, cut at 8 bytes
    tbl.push_back(v(2, 'hA000, 0, 0, 1, 'h00, 0, 0, 0, 0));
    tbl.push_back(v(2, 'hA000, 0, 2, 1, 'h00, 1, 1, 0, 0));
    tbl.push_back(v(2, 'hA100, 0, 2, 1, 'hA0, 1, 1, 0, 0));
    tbl.push_back(v(2, 'hA200, 0, 2, 0, 'hA1, 1, 1, 0, 0));
    tbl.push_back(v(2, 'hA300, 0, 2, 0, 'hA2, 1, 1, 0, 0));
    tbl.push_back(v(2, 'hA400, 0, 2, 0, 'hA3, 1, 1, 0, 0));
    tbl.push_back(v(2, 'hA500, 0, 2, 0, 'hA4, 1, 1, 0, 0));
    tbl.push_back(v(2, 'hA600, 0, 2, 0, 'hA5, 1, 1, 0, 0));
    tbl.push_back(v(2, 'hA700, 0, 2, 0, 'hA6, 1, 1, 0, 0));
    tbl.push_back(v(2, 'hA800, 0, 0, 0, 'hA7, 1, 1, 0, 1));
    tbl.push_back(v(0, 'h00, 0, 0, 1, 'h00, 0, 1, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      valid = tbl[i].valid;
      data  = tbl[i].data;
      last  = tbl[i].last;
      @(negedge clk);
      chk($sformatf("vec%0d", i), {14'd0, ready, ctl, ldata, busy, gid, uu, ov},
          {14'd0, tbl[i].exp});
      @(posedge clk); #1;
    end

    // All four contend from reset: served 0,1,2,3, 6 cycles per packet
    do_reset();
    for (int p = 0; p < 4; p++) load(p, 4, 16 * (p + 1));
    repeat (30) cyc();
    chk("t2_count", 32'(cap_d.size()), 32'd16);
    for (int n = 0; n < cap_d.size() && n < 16; n++)
      chk($sformatf("t2_byte%0d", n), {21'd0, cap_c[n], cap_g[n], cap_d[n]},
          {21'd0, 1'(n % 4 == 0), 2'(n / 4), 8'(16 * (n / 4 + 1) + n % 4)});
    for (int p = 1; p < 4; p++)
      if (cap_t.size() > 4 * p)
        chk($sformatf("t2_spacing%0d", p), 32'(cap_t[4*p] - cap_t[4*p-4]), 32'd6);

    // After src2, src1 and src3 contend: src3 first
    do_reset();
    load(2, 3, 'h31);
    repeat (8) cyc();
    cap_clear();
    load(1, 2, 'h41);
    load(3, 2, 'h61);
    repeat (14) cyc();
    chk("t3_count", 32'(cap_d.size()), 32'd4);
    if (cap_d.size() >= 4) begin
      chk("t3_b0", {21'd0, cap_c[0], cap_g[0], cap_d[0]}, {21'd0, 1'b1, 2'd3, 8'h61});
      chk("t3_b1", {21'd0, cap_c[1], cap_g[1], cap_d[1]}, {21'd0, 1'b0, 2'd3, 8'h62});
      chk("t3_b2", {21'd0, cap_c[2], cap_g[2], cap_d[2]}, {21'd0, 1'b1, 2'd1, 8'h41});
      chk("t3_b3", {21'd0, cap_c[3], cap_g[3], cap_d[3]}, {21'd0, 1'b0, 2'd1, 8'h42});
    end

    // Reset mid-packet from src2, then contended arbitration must start at src0
    cap_clear();
    load(2, 6, 'h71);
    for (int k = 0; k < 20 && cap_d.size() < 3; k++) cyc();
    chk("t6_third_byte", 32'(cap_d.size()), 32'd3);
    rst = 1'b1;
    cyc();
    chk("t6_after_rst", {15'd0, ready, ctl, ldata, busy, gid, uu, ov},
        {15'd0, 4'b0000, 1'b1, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0});
    rst = 1'b0;
    cap_clear();
    load(0, 2, 'h81);
    load(3, 1, 'h91);
    repeat (10) cyc();
    chk("t6_count", 32'(cap_d.size() >= 1), 32'd1);
    if (cap_d.size() >= 1)
      chk("t6_first_hdr", {21'd0, cap_c[0], cap_g[0], cap_d[0]}, {21'd0, 1'b1, 2'd0, 8'h81});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
